// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with load, lock-up reseed and optional
// period measurement (enabled by defining LFSR_PERIOD_CNT_EN).
module lfsr_gen #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01,
    parameter bit              XNOR  = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] out_o,
    output logic             bit_out_o,
    output logic             lockup_o,
    output logic [WIDTH-1:0] period_o,
    output logic             period_done_o
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] lock_val;
    logic [WIDTH-1:0] fib_nxt, gal_nxt, step_nxt;
    logic             fb;
    logic             reseed;

    // XNOR polarity only affects the Fibonacci structure.
    assign lock_val  = (!mode_i && XNOR) ? '1 : '0;
    assign lockup_o  = (out_q == lock_val);
    assign fb        = (^(out_q & TAPS)) ^ XNOR;
    assign fib_nxt   = {out_q[WIDTH-2:0], fb};
    assign gal_nxt   = (out_q >> 1) ^ (out_q[0] ? TAPS : '0);
    assign step_nxt  = mode_i ? gal_nxt : fib_nxt;
    assign reseed    = en_i && lockup_o && !load_i;
    assign out_o     = out_q;
    assign bit_out_o = mode_i ? out_q[0] : out_q[WIDTH-1];

    always_comb begin
        out_d = out_q;
        if (load_i)
            out_d = load_val_i;
        else if (reseed)
            out_d = SEED;
        else if (en_i)
            out_d = step_nxt;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            out_q <= SEED;
        else
            out_q <= out_d;
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             done_q, done_d;
    logic             mode_q;

    always_comb begin
        cnt_d    = cnt_q;
        ref_d    = ref_q;
        period_d = period_q;
        done_d   = 1'b0;
        if (load_i) begin
            cnt_d = '0;
            ref_d = load_val_i;
        end else if (reseed) begin
            cnt_d = '0;
            ref_d = SEED;
        end else if (mode_i != mode_q) begin
            // Restart measurement from the pre-step state; a step taken now counts.
            ref_d = out_q;
            cnt_d = WIDTH'(en_i);
        end else if (en_i) begin
            if (step_nxt == ref_q) begin
                period_d = cnt_q + 1'b1;
                done_d   = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            ref_q    <= SEED;
            period_q <= '0;
            done_q   <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ref_q    <= ref_d;
            period_q <= period_d;
            done_q   <= done_d;
            mode_q   <= mode_i;
        end
    end

    assign period_o      = period_q;
    assign period_done_o = done_q;
`else
    assign period_o      = '0;
    assign period_done_o = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: two instances (XOR and XNOR polarity) share
// stimulus; a reference model predicts each cycle and a monitor checks it.
module tb_lfsr_gen;

    localparam int         W  = 4;
    localparam logic [3:0] TP = 4'hC;
    localparam logic [3:0] SD = 4'h1;
`ifdef LFSR_PERIOD_CNT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, load, mode;
    logic [3:0] lval;
    logic [3:0] out0, out1, per0, per1;
    logic       bo0, bo1, lk0, lk1, pd0, pd1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(W), .TAPS(TP), .SEED(SD), .XNOR(1'b0)) u0 (
        .clk_i(clk), .reset_i(rst), .en_i(en), .load_i(load), .load_val_i(lval),
        .mode_i(mode), .out_o(out0), .bit_out_o(bo0), .lockup_o(lk0),
        .period_o(per0), .period_done_o(pd0));

    lfsr_gen #(.WIDTH(W), .TAPS(TP), .SEED(SD), .XNOR(1'b1)) u1 (
        .clk_i(clk), .reset_i(rst), .en_i(en), .load_i(load), .load_val_i(lval),
        .mode_i(mode), .out_o(out1), .bit_out_o(bo1), .lockup_o(lk1),
        .period_o(per1), .period_done_o(pd1));

    typedef struct {int out; bit lk; bit bo; int per; bit pd;} exp_t;
    typedef struct {int out; int refv; int cnt; int per; bit pd; bit mprev;} mdl_t;

    mdl_t m0, m1;
    exp_t q0[$], q1[$];

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lock_of(bit md, bit xn);
        return (!md && xn) ? 15 : 0;
    endfunction

    function automatic int fib(int s, bit xn);
        int ones;
        ones = 0;
        for (int i = 0; i < W; i++)
            if (((s >> i) & 1) == 1 && ((int'(TP) >> i) & 1) == 1) ones++;
        return ((s * 2) % 16) + (((ones % 2) == 1) != xn ? 1 : 0);
    endfunction

    function automatic int gal(int s);
        return (s / 2) ^ ((s % 2) == 1 ? int'(TP) : 0);
    endfunction

    function automatic mdl_t mstep(mdl_t s, bit e, bit ld, int v, bit md, bit xn);
        mdl_t n;
        bit   lk;
        int   nx;
        n = s;
        n.pd = 1'b0;
        n.mprev = md;
        lk = (s.out == lock_of(md, xn));
        nx = md ? gal(s.out) : fib(s.out, xn);
        if (ld) begin
            n.out = v; n.cnt = 0; n.refv = v;
        end else if (e && lk) begin
            n.out = SD; n.cnt = 0; n.refv = SD;
        end else begin
            if (e) n.out = nx;
            if (md != s.mprev) begin
                n.refv = s.out;
                n.cnt  = e ? 1 : 0;
            end else if (e) begin
                if (nx == s.refv) begin
                    n.per = s.cnt + 1; n.pd = 1'b1; n.cnt = 0;
                end else begin
                    n.cnt = s.cnt + 1;
                end
            end
        end
        return n;
    endfunction

    function automatic exp_t mexp(mdl_t s, bit md, bit xn);
        exp_t x;
        x.out = s.out;
        x.lk  = (s.out == lock_of(md, xn));
        x.bo  = md ? s.out[0] : s.out[3];
        x.per = FEAT ? s.per : 0;
        x.pd  = FEAT ? s.pd : 1'b0;
        return x;
    endfunction

    task automatic mreset();
        m0 = '{out: SD, refv: SD, cnt: 0, per: 0, pd: 1'b0, mprev: 1'b0};
        m1 = m0;
    endtask

    // Drive one cycle of stimulus (called just after a falling edge).
    task automatic cyc(bit e, bit ld, logic [3:0] v, bit md);
        en = e; load = ld; lval = v; mode = md;
        m0 = mstep(m0, e, ld, int'(v), md, 1'b0);
        m1 = mstep(m1, e, ld, int'(v), md, 1'b1);
        q0.push_back(mexp(m0, md, 1'b0));
        q1.push_back(mexp(m1, md, 1'b1));
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                x = q0.pop_front();
                chk("u0_out", int'(out0), x.out);
                chk("u0_lockup", int'(lk0), int'(x.lk));
                chk("u0_bit_out", int'(bo0), int'(x.bo));
                chk("u0_period", int'(per0), x.per);
                chk("u0_period_done", int'(pd0), int'(x.pd));
            end
            if (q1.size() > 0) begin
                x = q1.pop_front();
                chk("u1_out", int'(out1), x.out);
                chk("u1_lockup", int'(lk1), int'(x.lk));
                chk("u1_bit_out", int'(bo1), int'(x.bo));
                chk("u1_period", int'(per1), x.per);
                chk("u1_period_done", int'(pd1), int'(x.pd));
            end
        end
    end

    initial begin : driver
        int fib_tab[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
        int gal_tab[15] = '{1, 12, 6, 3, 13, 10, 5, 14, 7, 15, 11, 9, 8, 4, 2};
        bit seen[16];
        bit md_r;
        bit e_r, ld_r;
        logic [3:0] v_r;

        rst = 1'b1; en = 1'b0; load = 1'b0; lval = '0; mode = 1'b0;
        mreset();
        repeat (2) @(negedge clk);
        chk("rst_out0", int'(out0), 1);
        chk("rst_out1", int'(out1), 1);
        chk("rst_lockup0", int'(lk0), 0);
        chk("rst_lockup1", int'(lk1), 0);
        chk("rst_period", int'(per0), 0);
        chk("rst_pdone", int'(pd0), 0);
        rst = 1'b0;

        for (int k = 1; k <= 15; k++) begin
            cyc(1'b1, 1'b0, 4'h0, 1'b0);
            chk("fib_seq", int'(out0), fib_tab[k % 15]);
        end
        chk("fib_pdone", int'(pd0), int'(FEAT));
        chk("fib_period", int'(per0), FEAT ? 15 : 0);

        for (int k = 1; k <= 15; k++) begin
            cyc(1'b1, 1'b0, 4'h0, 1'b1);
            chk("gal_seq", int'(out0), gal_tab[k % 15]);
        end
        chk("gal_pdone", int'(pd0), int'(FEAT));
        chk("gal_period", int'(per0), FEAT ? 15 : 0);

        cyc(1'b0, 1'b1, 4'h0, 1'b0);
        chk("load0_out", int'(out0), 0);
        chk("load0_lockup", int'(lk0), 1);
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        chk("reseed_out", int'(out0), 1);
        chk("reseed_lockup", int'(lk0), 0);
        chk("reseed_pdone", int'(pd0), 0);

        cyc(1'b1, 1'b1, 4'h7, 1'b0);
        chk("load_en_out", int'(out0), 7);
        repeat (5) cyc(1'b0, 1'b0, 4'h0, 1'b0);
        chk("hold_out", int'(out0), 7);

        md_r = 1'b0;
        repeat (400) begin
            e_r  = ($urandom_range(0, 3) != 0);
            ld_r = ($urandom_range(0, 15) == 0);
            v_r  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) md_r = ~md_r;
            cyc(e_r, ld_r, v_r, md_r);
        end

        cyc(1'b0, 1'b1, 4'hF, 1'b0);
        chk("xnor_lockup", int'(lk1), 1);
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        chk("xnor_reseed", int'(out1), 1);
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        seen[1] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cyc(1'b1, 1'b0, 4'h0, 1'b0);
            chk("xnor_not_f", int'(out1 == 4'hF), 0);
            chk("xnor_distinct", int'(seen[out1]), 0);
            seen[out1] = 1'b1;
        end
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        chk("xnor_wrap", int'(out1), 1);

        rst = 1'b1;
        mreset();
        @(negedge clk);
        rst = 1'b0;
        repeat (7) cyc(1'b1, 1'b0, 4'h0, 1'b0);
        chk("pre_async_out", int'(out0), 10);
        #2 rst = 1'b1;
        #1;
        chk("async_out0", int'(out0), 1);
        chk("async_out1", int'(out1), 1);
        chk("async_period", int'(per0), 0);
        chk("async_pdone", int'(pd0), 0);
        mreset();
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        chk("post_async_step", int'(out0), 2);

        @(posedge clk);
        #3;
        chk("queue_drained", q0.size() + q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
